snake_segment_writer: RTL and testbench
=======================================

Name: snake_segment_writer

Overview:
Parametrised successor to the fixed 16-bit snake writer. On a start pulse it snapshots a packed snake segment vector and a run-time length. It then streams one grid write per segment to the grid memory writer over a valid/ready handshake, with distinct cell codes for head and body. Out-of-grid segments are skipped, and a done pulse is issued per frame. It sits between the game-logic snake register and the grid/VGA memory writer.

Parameters:
COORD_W, 4, bits per x or y coordinate
MAX_LEN, 225, maximum number of segments held in snake_in
LEN_W, 8, width of snake_len; must hold MAX_LEN
GRID_W, 15, valid x range 0..GRID_W-1
GRID_H, 15, valid y range 0..GRID_H-1
HEAD_CODE, 2'b11, data_out value for segment 0
BODY_CODE, 2'b10, data_out value for segments 1..len-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a frame; sampled only in IDLE
snake_in  in  MAX_LEN*2*COORD_W  packed segments; segment k = snake_in[k*2*COORD_W +: 2*COORD_W], y = upper COORD_W bits, x = lower COORD_W bits
snake_len  in  LEN_W  number of valid segments, sampled with start
wr_ready  in  1  grid writer accepts the current write
wr_valid  out  1  x_loc/y_loc/data_out hold a write
x_loc  out  COORD_W  write column
y_loc  out  COORD_W  write row
data_out  out  2  cell code (HEAD_CODE or BODY_CODE)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at frame end
len_err  out  1  one-cycle pulse, coincident with done, when snake_len is 0 or > MAX_LEN
oob  out  1  sticky: at least one segment was skipped this frame; cleared on the next accepted start

Behaviour:
- Reset (async): FSM goes to IDLE; wr_valid, x_loc, y_loc, data_out, busy, done, len_err, oob = 0; segment index = 0. A reset mid-frame aborts the frame; no further writes and no done.
- FSM states are IDLE, SCAN, WRITE, FIN.
- IDLE: when start=1, latch snake_in into a shadow register and snake_len into len_q; clear oob; set idx=0.
  - If snake_len==0 or snake_len>MAX_LEN, go to FIN with the error flag set.
  - Otherwise go to SCAN.
- SCAN (one cycle per segment): examine shadow segment idx.
  - If x>=GRID_W or y>=GRID_H, set oob=1, increment idx, and stay in SCAN. If idx was len_q-1, go to FIN instead.
  - If in range, load x_loc/y_loc, set data_out = HEAD_CODE if idx==0, else BODY_CODE. Assert wr_valid and go to WRITE.
- WRITE: hold wr_valid and x_loc/y_loc/data_out stable while wr_ready=0.
  - On wr_valid&&wr_ready, drop wr_valid the next cycle and increment idx.
  - If the accepted segment was idx==len_q-1, go to FIN; otherwise go to SCAN.
- FIN: done=1 for exactly one cycle; len_err=1 in that same cycle if the error flag is set. Then return to IDLE.
- Latency: start accepted at cycle N → first wr_valid at N+2. With wr_ready tied high and all segments in range, each segment takes 2 cycles (scan + write), so done asserts at cycle N+2*len+1.
- start while busy is ignored; it does not queue or restart.
- snake_in/snake_len changes after start do not affect the frame in progress, because the shadow copy is used.
- The head code is tied to segment index 0. If segment 0 is skipped as out-of-grid, no head is written and no body segment is promoted.
- idx is LEN_W wide and never exceeds len_q-1; there is no wrap-around.
- x_loc/y_loc/data_out retain their last values after the frame; only wr_valid qualifies them.

Test Plan:
- Basic frame, wr_ready=1: start with len=3, segments (x,y)=(5,7),(4,7),(3,7) → writes (5,7,11),(4,7,10),(3,7,10); first wr_valid 2 cycles after start; done pulses at N+7; oob=0, len_err=0.
- Backpressure: len=2, wr_ready low for 4 cycles on the first write → wr_valid and outputs held stable for those cycles; exactly 2 handshakes total; one done.
- Out of grid: len=3, segment 1=(15,2) with GRID_W=15 → only segments 0 and 2 written; oob=1 after frame; oob clears on the next start.
- Length errors: snake_len=0, then snake_len=MAX_LEN+1 → no wr_valid; done and len_err pulse together one cycle later; busy high for exactly 1 cycle.
- Start while busy plus input change: second start pulse and a snake_in change mid-frame → original frame data written; no restart; one done.
- Async reset mid-frame: assert reset during WRITE with wr_ready=0 → all outputs 0 immediately; no done; a new start afterwards runs a clean frame from segment 0.

Source files
------------

// File: rtl/snake_segment_writer.sv
// Streams one grid write per snake segment from a shadow copy of the snake vector.
// Head (segment 0) and body segments get distinct cell codes; out-of-grid segments are skipped.
module snake_segment_writer #(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned MAX_LEN   = 225,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned GRID_W    = 15,
  parameter int unsigned GRID_H    = 15,
  parameter logic [1:0]  HEAD_CODE = 2'b11,
  parameter logic [1:0]  BODY_CODE = 2'b10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [MAX_LEN*2*COORD_W-1:0]   snake_in,
  input  logic [LEN_W-1:0]               snake_len,
  input  logic                           wr_ready,
  output logic                           wr_valid,
  output logic [COORD_W-1:0]             x_loc,
  output logic [COORD_W-1:0]             y_loc,
  output logic [1:0]                     data_out,
  output logic                           busy,
  output logic                           done,
  output logic                           len_err,
  output logic                           oob
);

  localparam int unsigned SegW = 2 * COORD_W;

  // One extra bit so grid/length limits equal to 2**width still compare correctly.
  localparam logic [COORD_W:0] GridWL  = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0] GridHL  = (COORD_W + 1)'(GRID_H);
  localparam logic [LEN_W:0]   MaxLenL = (LEN_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StScan, StWrite, StFin} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;
  logic               oob_q, oob_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [1:0]         code_q, code_d;
  logic               load_shadow;

  logic [SegW-1:0]    shadow_q [MAX_LEN];
  logic [SegW-1:0]    cur_seg;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               in_grid;
  logic               last_seg;
  logic               len_bad;

  // Shadow copy decouples the frame from later changes to snake_in.
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        shadow_q[k] <= snake_in[k*SegW +: SegW];
      end
    end
  end

  always_comb begin
    cur_seg  = shadow_q[idx_q];
    cur_x    = cur_seg[COORD_W-1:0];
    cur_y    = cur_seg[SegW-1:COORD_W];
    in_grid  = ({1'b0, cur_x} < GridWL) && ({1'b0, cur_y} < GridHL);
    last_seg = (idx_q == (len_q - LEN_W'(1)));
    len_bad  = (snake_len == '0) || ({1'b0, snake_len} > MaxLenL);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    err_d       = err_q;
    oob_d       = oob_q;
    x_d         = x_q;
    y_d         = y_q;
    code_d      = code_q;
    load_shadow = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_shadow = 1'b1;
          len_d       = snake_len;
          oob_d       = 1'b0;
          idx_d       = '0;
          err_d       = len_bad;
          state_d     = len_bad ? StFin : StScan;
        end
      end
      StScan: begin
        if (!in_grid) begin
          oob_d = 1'b1;
          if (last_seg) begin
            state_d = StFin;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end else begin
          x_d     = cur_x;
          y_d     = cur_y;
          code_d  = (idx_q == '0) ? HEAD_CODE : BODY_CODE;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wr_ready) begin
          if (last_seg) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = StScan;
          end
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      oob_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
      oob_q   <= oob_d;
      x_q     <= x_d;
      y_q     <= y_d;
      code_q  <= code_d;
    end
  end

  // Status outputs decode directly from the state register so reset clears them at once.
  assign wr_valid = (state_q == StWrite);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign len_err  = done & err_q;
  assign oob      = oob_q;
  assign x_loc    = x_q;
  assign y_loc    = y_q;
  assign data_out = code_q;

endmodule

// File: tb/tb_snake_segment_writer.sv
// Scoreboard bench for snake_segment_writer: expected writes are queued as frames are set up
// and compared against every accepted handshake.
module tb_snake_segment_writer;

  localparam int MAX_LEN = 225;
  localparam int COORD_W = 4;
  localparam int LEN_W   = 8;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         start;
  logic [MAX_LEN*2*COORD_W-1:0] snake_in;
  logic [LEN_W-1:0]             snake_len;
  logic                         wr_ready;
  logic                         wr_valid;
  logic [COORD_W-1:0]           x_loc;
  logic [COORD_W-1:0]           y_loc;
  logic [1:0]                   data_out;
  logic                         busy;
  logic                         done;
  logic                         len_err;
  logic                         oob;

  snake_segment_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .snake_in (snake_in),
    .snake_len(snake_len),
    .wr_ready (wr_ready),
    .wr_valid (wr_valid),
    .x_loc    (x_loc),
    .y_loc    (y_loc),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .len_err  (len_err),
    .oob      (oob)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [9:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid && wr_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else check("write", 32'({x_loc, y_loc, data_out}), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Place segment k and queue the write it should produce, if any.
  task automatic seg(input int k, input int x, input int y);
    logic [3:0] xb;
    logic [3:0] yb;
    xb = x[3:0];
    yb = y[3:0];
    snake_in[k*8 +: 8] = {yb, xb};
    if (x < 15 && y < 15) exp_q.push_back({xb, yb, (k == 0) ? 2'b11 : 2'b10});
  endtask

  task automatic start_frame(input int len);
    snake_len = len[LEN_W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat, output logic le);
    while (!done && (cyc - start_cyc) < budget) tick();
    if (!done) check("done_timeout", 32'd0, 32'd1);
    lat = cyc - start_cyc;
    le = len_err;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int t;
    t = 0;
    while (!wr_valid && t < budget) begin
      tick();
      t++;
    end
    if (!wr_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic le;
    int d0;
    int h0;

    reset = 1'b1;
    start = 1'b0;
    snake_in = '0;
    snake_len = '0;
    wr_ready = 1'b1;
    tick();
    tick();
    check("rst_outputs", 32'({wr_valid, x_loc, y_loc, data_out, busy, done, len_err, oob}), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic frame
    snake_in = '0;
    seg(0, 5, 7); seg(1, 4, 7); seg(2, 3, 7);
    d0 = done_cnt;
    start_frame(3);
    check("basic_valid_n1", 32'(wr_valid), 32'd0);
    check("basic_busy", 32'(busy), 32'd1);
    tick();
    check("basic_valid_n2", 32'(wr_valid), 32'd1);
    check("basic_first", 32'({x_loc, y_loc, data_out}), 32'({4'd5, 4'd7, 2'b11}));
    wait_done(40, lat, le);
    check("basic_latency", 32'(lat), 32'd6);
    check("basic_len_err", 32'(le), 32'd0);
    check("basic_oob", 32'(oob), 32'd0);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on the first write
    snake_in = '0;
    seg(0, 1, 1); seg(1, 2, 3);
    wr_ready = 1'b0;
    d0 = done_cnt;
    h0 = hs_cnt;
    start_frame(2);
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid_held", 32'(wr_valid), 32'd1);
      check("bp_data_held", 32'({x_loc, y_loc, data_out}), 32'({4'd1, 4'd1, 2'b11}));
      tick();
    end
    wr_ready = 1'b1;
    wait_done(40, lat, le);
    check("bp_latency", 32'(lat), 32'd8);
    check("bp_handshakes", 32'(hs_cnt - h0), 32'd2);
    check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Middle segment out of grid
    snake_in = '0;
    seg(0, 0, 0); seg(1, 15, 2); seg(2, 14, 14);
    start_frame(3);
    wait_done(40, lat, le);
    check("oob_latency", 32'(lat), 32'd5);
    check("oob_set", 32'(oob), 32'd1);
    check("oob_sb_empty", 32'(exp_q.size()), 32'd0);

    // Head and last segment out of grid: no head written, no promotion
    snake_in = '0;
    seg(0, 3, 15); seg(1, 2, 2); seg(2, 9, 15);
    start_frame(3);
    check("oob_cleared_on_start", 32'(oob), 32'd0);
    wait_done(40, lat, le);
    check("oob_head_latency", 32'(lat), 32'd4);
    check("oob_head_set", 32'(oob), 32'd1);
    check("oob_head_sb_empty", 32'(exp_q.size()), 32'd0);

    // Length errors
    for (int j = 0; j < 2; j++) begin
      h0 = hs_cnt;
      d0 = done_cnt;
      start_frame((j == 0) ? 0 : MAX_LEN + 1);
      check("lerr_flags", 32'({busy, done, len_err, wr_valid}), 32'b1110);
      tick();
      check("lerr_after", 32'({busy, done, len_err}), 32'd0);
      check("lerr_no_write", 32'(hs_cnt - h0), 32'd0);
      check("lerr_done_cnt", 32'(done_cnt - d0), 32'd1);
    end

    // Start while busy plus input change mid-frame
    snake_in = '0;
    seg(0, 10, 1); seg(1, 11, 1); seg(2, 12, 1);
    d0 = done_cnt;
    start_frame(3);
    tick();
    snake_in = '1;
    snake_len = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, lat, le);
    check("busy_start_latency", 32'(lat), 32'd6);
    check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
    tick(); tick();
    check("busy_start_no_restart", 32'(busy), 32'd0);
    check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset mid-WRITE
    snake_in = '0;
    seg(0, 6, 6); seg(1, 7, 7);
    wr_ready = 1'b0;
    d0 = done_cnt;
    start_frame(2);
    wait_valid(10);
    #2 reset = 1'b1;
    #1;
    check("arst_outputs", 32'({wr_valid, x_loc, y_loc, data_out, busy, done, len_err, oob}), 32'd0);
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);
    wr_ready = 1'b1;
    seg(0, 6, 6); seg(1, 7, 7);
    start_frame(2);
    wait_done(40, lat, le);
    check("arst_clean_latency", 32'(lat), 32'd4);
    check("arst_clean_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
